// File: rtl/vic_wb_buffer_if.sv
// vic_wb_buffer_if: victim fire, load-miss probe and memory store signals of the write-back queue
interface vic_wb_buffer_if #(
  parameter int ADDR_BITS = 13
);
  logic [1:0]                fired_valid;
  logic [1:0][63:0]          fired_data;
  logic [1:0][ADDR_BITS-1:0] fired_addr;
  logic                      wb_ready;
  logic                      lookup_valid;
  logic [ADDR_BITS-1:0]      lookup_addr;
  logic                      lookup_hit;
  logic [63:0]               lookup_data;
  logic                      mem_grant;
  logic [3:0]                mem_response;
  logic [1:0]                proc2mem_command;
  logic [63:0]               proc2mem_addr;
  logic [63:0]               proc2mem_data;
  modport master (
    output fired_valid, fired_data, fired_addr, lookup_valid, lookup_addr, mem_grant, mem_response,
    input  wb_ready, lookup_hit, lookup_data, proc2mem_command, proc2mem_addr, proc2mem_data
  );
  modport slave (
    input  fired_valid, fired_data, fired_addr, lookup_valid, lookup_addr, mem_grant, mem_response,
    output wb_ready, lookup_hit, lookup_data, proc2mem_command, proc2mem_addr, proc2mem_data
  );
endinterface

// File: rtl/vic_wb_buffer.sv
// vic_wb_buffer: coalescing victim write-back FIFO draining as BUS_STORE; WB_FWD_EN adds load-miss forwarding and fwd_hits
module vic_wb_buffer #(
  parameter int WB_DEPTH  = 4,
  parameter int ADDR_BITS = 13
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  vic_wb_buffer_if.slave            wb,
  input  logic                      flush_i,
  output logic                      flush_done_o,
  output logic [$clog2(WB_DEPTH):0] count_o
`ifdef WB_FWD_EN
  ,output logic [31:0]              fwd_hits_o
`endif
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q [WB_DEPTH];
  logic [63:0]          data_q [WB_DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WB_DEPTH-1:0]  live, m0, m1;
  logic                 pop, v0, a0, a1;
  logic                 flush_unused;
  // flush only observes the queue through flush_done; it never stalls anything
  assign flush_unused = flush_i;
  // per lane: coalesce into a live non-head entry, else allocate at tail if room remains
  always_comb begin
    pop = state_q == ISSUE && wb.mem_grant && wb.mem_response != 4'd0;
    v0  = wb.fired_valid[0] && !(wb.fired_valid[1] && wb.fired_addr[0] == wb.fired_addr[1]);
    for (int i = 0; i < WB_DEPTH; i++) begin
      live[i] = {1'b0, PW'(i) - head_q} < count_q && !(state_q == ISSUE && PW'(i) == head_q);
      m0[i]   = v0 && live[i] && addr_q[i] == wb.fired_addr[0];
      m1[i]   = wb.fired_valid[1] && live[i] && addr_q[i] == wb.fired_addr[1];
    end
    a0      = v0 && m0 == '0 && count_q < CW'(WB_DEPTH);
    a1      = wb.fired_valid[1] && m1 == '0 && count_q + CW'(a0) < CW'(WB_DEPTH);
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(a0) + PW'(a1);
    count_d = count_q - CW'(pop) + CW'(a0) + CW'(a1);
  end
  // entry storage: in-place coalescing writes plus tail allocation; lane 1 lands after lane 0
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (m0[i]) data_q[i] <= wb.fired_data[0];
      if (m1[i]) data_q[i] <= wb.fired_data[1];
    end
    if (a0) begin
      addr_q[tail_q] <= wb.fired_addr[0];
      data_q[tail_q] <= wb.fired_data[0];
    end
    if (a1) begin
      addr_q[tail_q + PW'(a0)] <= wb.fired_addr[1];
      data_q[tail_q + PW'(a0)] <= wb.fired_data[1];
    end
  end
  // pointer, occupancy and state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // issue whenever anything will be queued after this edge; so a fresh victim goes out next cycle
  always_comb state_d = count_d != '0 ? ISSUE : IDLE;
  // bus outputs follow the frozen head while issuing
  always_comb begin
    wb.proc2mem_command = state_q == ISSUE ? BUS_STORE : BUS_NONE;
    wb.proc2mem_addr    = state_q == ISSUE ? {{(61-ADDR_BITS){1'b0}}, addr_q[head_q], 3'b000} : 64'd0;
    wb.proc2mem_data    = state_q == ISSUE ? data_q[head_q] : 64'd0;
    wb.wb_ready         = count_q <= CW'(WB_DEPTH - 2);
    flush_done_o        = count_q == '0 && state_q == IDLE;
    count_o             = count_q;
  end
`ifdef WB_FWD_EN
  logic [31:0] fwd_hits_q;
  // youngest match wins: scan head to tail, then incoming lane 0, then lane 1
  always_comb begin
    wb.lookup_hit  = 1'b0;
    wb.lookup_data = 64'd0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if ({1'b0, PW'(k)} < count_q && addr_q[head_q + PW'(k)] == wb.lookup_addr) begin
        wb.lookup_hit  = 1'b1;
        wb.lookup_data = data_q[head_q + PW'(k)];
      end
    end
    for (int l = 0; l < 2; l++) begin
      if (wb.fired_valid[l] && wb.fired_addr[l] == wb.lookup_addr) begin
        wb.lookup_hit  = 1'b1;
        wb.lookup_data = wb.fired_data[l];
      end
    end
    wb.lookup_hit  = wb.lookup_valid && wb.lookup_hit;
    wb.lookup_data = wb.lookup_valid ? wb.lookup_data : 64'd0;
  end
  // saturating forward-hit statistic
  always_ff @(posedge clk_i) begin
    if (rst_i) fwd_hits_q <= '0;
    else if (wb.lookup_hit && fwd_hits_q != '1) fwd_hits_q <= fwd_hits_q + 32'd1;
  end
  assign fwd_hits_o = fwd_hits_q;
`else
  logic lookup_unused;
  assign lookup_unused  = ^{wb.lookup_valid, wb.lookup_addr};
  assign wb.lookup_hit  = 1'b0;
  assign wb.lookup_data = 64'd0;
`endif
endmodule
